// File: rtl/out_port_seg_ctrl_pkg.sv
// out_port_seg_pkg: shared FSM states, segment patterns and conversion length.
package out_port_seg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;
    localparam int ITERS = 7;
    localparam logic [0:9][6:0] SEG_DIGIT = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_RESET = 7'b1000000;
endpackage

// File: rtl/out_port_seg_ctrl_if.sv
// out_port_seg_ctrl_if: CPU output-port handshakes plus the HEX digit bus.
interface out_port_seg_ctrl_if;
    logic        req0, req1, ack0, ack1, busy;
    logic [31:0] val0, val1;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    modport master (output req0, val0, req1, val1,
                    input  ack0, ack1, busy, HEX0, HEX1, HEX2, HEX3);
    modport slave  (input  req0, val0, req1, val1,
                    output ack0, ack1, busy, HEX0, HEX1, HEX2, HEX3);
endinterface

// File: rtl/out_port_seg_ctrl_seg7_decode.sv
// seg7_decode: BCD nibble to active-low gfedcba pattern; non-decimal nibbles blank.
module seg7_decode
    import out_port_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = (digit <= 4'd9) ? SEG_DIGIT[digit] : SEG_BLANK;
endmodule

// File: rtl/out_port_seg_ctrl.sv
// out_port_seg_ctrl: arbitrates two output ports onto one shift-and-add-3
// converter and registers the decoded digits into the granted HEX pair.
module out_port_seg_ctrl
    import out_port_seg_pkg::*;
#(
    parameter bit DASH_ON_OVF = 1'b1
) (
    input logic               clock,
    input logic               reset,
    out_port_seg_ctrl_if.slave bus
);
    state_t      state, next;
    logic        grant, last, pick, ovf, dash;
    logic [6:0]  bin, tens_seg, ones_seg;
    logic [7:0]  bcd, adj;
    logic [2:0]  iter;
    logic [31:0] val;

    // A tie goes to the port that was not granted last time.
    assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
    assign val  = grant ? bus.val1 : bus.val0;
    assign adj  = {(bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4],
                   (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0]};
    assign dash = ovf && DASH_ON_OVF;

    seg7_decode u_tens (.digit(bcd[7:4]), .seg(tens_seg));
    seg7_decode u_ones (.digit(bcd[3:0]), .seg(ones_seg));

    always_comb begin
        next     = state;
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        bus.busy = state != IDLE;
        case (state)
            IDLE:  next = (bus.req0 || bus.req1) ? LOAD : IDLE;
            LOAD: begin
                next     = SHIFT;
                bus.ack0 = ~grant;
                bus.ack1 = grant;
            end
            SHIFT: next = (iter == 3'(ITERS - 1)) ? WRITE : SHIFT;
            WRITE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            ovf     <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            iter    <= '0;
            bus.HEX0 <= SEG_RESET;
            bus.HEX1 <= SEG_RESET;
            bus.HEX2 <= SEG_RESET;
            bus.HEX3 <= SEG_RESET;
        end else begin
            state <= next;
            if (state == IDLE && (bus.req0 || bus.req1))
                grant <= pick;
            if (state == LOAD) begin
                bin  <= val[6:0];
                ovf  <= val > 32'd99;
                bcd  <= '0;
                iter <= '0;
                last <= grant;
            end
            if (state == SHIFT) begin
                {bcd, bin} <= {adj[6:0], bin, 1'b0};
                iter       <= iter + 3'd1;
            end
            if (state == WRITE && !grant) begin
                bus.HEX1 <= dash ? SEG_DASH : tens_seg;
                bus.HEX0 <= dash ? SEG_DASH : ones_seg;
            end
            if (state == WRITE && grant) begin
                bus.HEX3 <= dash ? SEG_DASH : tens_seg;
                bus.HEX2 <= dash ? SEG_DASH : ones_seg;
            end
        end
    end
endmodule

// File: tb/tb_out_port_seg_ctrl.sv
// tb_out_port_seg_ctrl: vector table, random updates against a decimal model,
// plus tie/fairness and reset-abort sequences.
module tb_out_port_seg_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    out_port_seg_ctrl_if bus ();
    out_port_seg_ctrl #(.DASH_ON_OVF(1'b1)) dut (.clock(clock), .reset(reset), .bus(bus));

    localparam logic [6:0] RST7 = 7'b1000000;
    localparam logic [6:0] DASH = 7'b0111111;
    // One job is LOAD + 7 SHIFT + WRITE, then one IDLE cycle before the next LOAD.
    localparam int GAP = 10;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_hex [4];

    typedef struct {
        int          port;
        logic [31:0] val;
        logic [6:0]  tens;
        logic [6:0]  ones;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [6:0] digit(int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] hex(int i);
        case (i)
            0: return bus.HEX0;
            1: return bus.HEX1;
            2: return bus.HEX2;
            default: return bus.HEX3;
        endcase
    endfunction

    function automatic void model(int p, logic [31:0] v);
        exp_hex[2*p+1] = (v > 99) ? DASH : digit(int'(v) / 10);
        exp_hex[2*p]   = (v > 99) ? DASH : digit(int'(v) % 10);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_hex(string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s HEX%0d", tag, i), 32'(hex(i)), 32'(exp_hex[i]));
    endtask

    task automatic set_req(int p, logic r);
        if (p == 0) bus.req0 = r; else bus.req1 = r;
    endtask

    task automatic update(int p, logic [31:0] v);
        int n, m;
        @(negedge clock);
        if (p == 0) bus.val0 = v; else bus.val1 = v;
        set_req(p, 1'b1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(p == 0 ? bus.ack0 : bus.ack1) && n < 40);
        check($sformatf("ack latency p%0d", p), n, 1);
        check("other ack idle", 32'(p == 0 ? bus.ack1 : bus.ack0), 0);
        set_req(p, 1'b0);
        model(p, v);
        m = 0;
        do begin
            @(negedge clock);
            m++;
        end while (bus.busy && m < 40);
        check("busy length", m, 9);
        check_hex($sformatf("upd p%0d v%0h", p, v));
    endtask

    initial begin
        int order [4];
        int at [4];
        int k, cyc, m;
        logic both, stray;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.val0 = '0;   bus.val1 = '0;
        for (int i = 0; i < 4; i++) exp_hex[i] = RST7;
        tbl[0] = '{0, 32'd37,        7'b0110000, 7'b1111000};
        tbl[1] = '{1, 32'd99,        7'b0010000, 7'b0010000};
        tbl[2] = '{1, 32'd100,       DASH,       DASH};
        tbl[3] = '{1, 32'hFFFFFFFF,  DASH,       DASH};
        tbl[4] = '{0, 32'd0,         7'b1000000, 7'b1000000};
        tbl[5] = '{0, 32'd5,         7'b1000000, 7'b0010010};
        tbl[6] = '{1, 32'd128,       DASH,       DASH};
        tbl[7] = '{0, 32'd88,        7'b0000000, 7'b0000000};

        repeat (2) @(negedge clock);
        check_hex("reset");
        check("reset busy", 32'(bus.busy), 0);
        check("reset acks", 32'({bus.ack0, bus.ack1}), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            update(tbl[i].port, tbl[i].val);
            check($sformatf("tbl%0d tens", i), 32'(hex(2*tbl[i].port+1)), 32'(tbl[i].tens));
            check($sformatf("tbl%0d ones", i), 32'(hex(2*tbl[i].port)), 32'(tbl[i].ones));
        end

        for (int i = 0; i < 24; i++)
            update($urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 120)));

        // Tie straight after reset, both requests held for four grants.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_hex[i] = RST7;
        bus.val0 = 32'd5; bus.val1 = 32'd99;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        k = 0; cyc = 0; both = 1'b0;
        while (k < 4 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (bus.ack0 && bus.ack1) both = 1'b1;
            if (bus.ack0 || bus.ack1) begin
                order[k] = bus.ack1 ? 1 : 0;
                at[k] = cyc;
                k++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("fair grants", k, 4);
        check("fair both acks", 32'(both), 0);
        check("fair first latency", at[0], 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair order %0d", i), order[i], i % 2);
            if (i > 0) check($sformatf("fair gap %0d", i), at[i] - at[i-1], GAP);
        end
        m = 0;
        while (bus.busy && m < 20) begin
            @(negedge clock);
            m++;
        end
        check("fair drained", 32'(bus.busy), 0);
        model(0, 32'd5);
        model(1, 32'd99);
        check_hex("fair");

        // Abort a conversion part-way through SHIFT.
        bus.val0 = 32'd42; bus.req0 = 1'b1;
        m = 0;
        do begin
            @(negedge clock);
            m++;
        end while (!bus.ack0 && m < 40);
        check("abort ack latency", m, 1);
        bus.req0 = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) exp_hex[i] = RST7;
        check_hex("async reset");
        check("async busy", 32'(bus.busy), 0);
        check("async acks", 32'({bus.ack0, bus.ack1}), 0);
        @(negedge clock); reset = 1'b0;
        stray = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.ack0 || bus.ack1 || bus.busy) stray = 1'b1;
        end
        check("abort no activity", 32'(stray), 0);
        check_hex("after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
